corner_chain_checker: RTL and testbench

Receive-and-check end of the corner-to-corner register-chain minitest. The block drives a PRBS7 bit stream into the head of a long-routed register chain, samples the chain tail, and compares the tail against its own delayed copy of the transmitted stream. It reports lock, a one-cycle error pulse and a saturating error count. It is the checking half of the routing/timing minitests and sits in the fabric next to the chain's last flop.

---
 rtl/corner_chain_checker.sv | 111 +++++++++++
 tb/tb_corner_chain_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/corner_chain_checker.sv
// corner_chain_checker: PRBS7 source and tail checker for the corner-to-corner register chain.
// Compares the chain tail against a delayed copy of tx; reports lock, error pulses and a saturating count.
module corner_chain_checker #(
    parameter int         CHAIN_LEN = 5,
    parameter int         LOCK_N    = 8,
    parameter int         LOSS_N    = 4,
    parameter int         ERR_W     = 16,
    parameter logic [6:0] SEED      = 7'h7F
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clr,
    input  logic             chain_in,
    output logic             tx,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, FILL, HUNT, LOCKED} state_t;

    localparam logic [7:0]       FILL_END = 8'(CHAIN_LEN - 1);
    localparam logic [7:0]       LOCK_END = 8'(LOCK_N - 1);
    localparam logic [7:0]       LOSS_END = 8'(LOSS_N - 1);
    localparam logic [ERR_W-1:0] CNT_MAX  = '1;

    state_t               state;
    logic [6:0]           lfsr;
    logic [CHAIN_LEN-1:0] hist;
    logic [7:0]           run;
    logic                 miss;

    // hist[CHAIN_LEN-1] holds tx from CHAIN_LEN cycles ago, aligned with an ideal chain tail
    assign miss = chain_in ^ hist[CHAIN_LEN-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            lfsr   <= SEED;
            hist   <= '0;
            run    <= '0;
            tx     <= 1'b0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else if (!enable) begin
            state  <= IDLE;
            lfsr   <= SEED;
            hist   <= '0;
            run    <= '0;
            tx     <= 1'b0;
            locked <= 1'b0;
            err    <= 1'b0;
        end else begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            tx   <= lfsr[6];
            hist <= (state == IDLE) ? '0 : (hist << 1) | CHAIN_LEN'(tx);
            err  <= 1'b0;
            // run counts FILL cycles, HUNT matches or LOCKED mismatches depending on state
            case (state)
                IDLE: begin
                    state <= FILL;
                    run   <= '0;
                end
                FILL: begin
                    if (run == FILL_END) begin
                        state <= HUNT;
                        run   <= '0;
                    end else begin
                        run <= run + 8'd1;
                    end
                end
                HUNT: begin
                    if (miss) begin
                        run <= '0;
                    end else if (run == LOCK_END) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                        run    <= '0;
                    end else begin
                        run <= run + 8'd1;
                    end
                end
                LOCKED: begin
                    if (!miss) begin
                        run <= '0;
                    end else begin
                        err <= 1'b1;
                        if (run == LOSS_END) begin
                            state  <= HUNT;
                            locked <= 1'b0;
                            run    <= '0;
                        end else begin
                            run <= run + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // clear wins over a coincident mismatch; the count survives drops of enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= '0;
        else if (clr)
            err_cnt <= '0;
        else if (enable && state == LOCKED && miss && err_cnt != CNT_MAX)
            err_cnt <= err_cnt + 1'b1;
    end
endmodule

// File: tb/tb_corner_chain_checker.sv
// tb_corner_chain_checker: random-stimulus bench comparing two checker instances against a cycle-count reference model.
// Instance a uses defaults; instance b uses ERR_W=3, LOSS_N=255 for saturation and clear-priority cases.
module tb_corner_chain_checker;
    localparam int L    = 5;
    localparam int LOCK = 8;

    typedef struct {
        int st;
        int n;
        int run;
        int cnt;
        bit err;
    } ms_t;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic       clr_a = 1'b0, clr_b = 1'b0, ci_a = 1'b0, ci_b = 1'b0;
    logic       tx_a, lk_a, err_a, tx_b, lk_b, err_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;

    bit   prbs[127];
    bit   ta[128];
    bit   hb[128];
    ms_t  ma, mb;
    int   d_a = L, mode_b = 0;
    bit   inv_a = 1'b0;
    int   n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    corner_chain_checker dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en), .clr(clr_a), .chain_in(ci_a),
        .tx(tx_a), .locked(lk_a), .err(err_a), .err_cnt(cnt_a)
    );

    corner_chain_checker #(.ERR_W(3), .LOSS_N(255)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en), .clr(clr_b), .chain_in(ci_b),
        .tx(tx_b), .locked(lk_b), .err(err_b), .err_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // n is the cycle number since FILL entry; expected tail bit is the PRBS bit sent L cycles earlier
    function automatic ms_t mstep(ms_t s, bit e_n, bit c, bit ci, int loss_n, int cmax);
        bit e;
        if (!e_n) begin
            s.st = 0; s.n = 0; s.run = 0; s.err = 0;
        end else begin
            e = (s.n > L) ? prbs[(s.n - L - 1) % 127] : 1'b0;
            s.err = 0;
            if (s.st == 0) s.st = 1;
            else if (s.st == 1) begin
                if (s.n == L) s.st = 2;
            end else if (s.st == 2) begin
                if (ci == e) begin
                    s.run++;
                    if (s.run == LOCK) begin s.st = 3; s.run = 0; end
                end else s.run = 0;
            end else if (ci != e) begin
                s.err = 1;
                if (s.cnt < cmax) s.cnt++;
                s.run++;
                if (s.run == loss_n) begin s.st = 2; s.run = 0; end
            end else s.run = 0;
            s.n++;
        end
        if (c) s.cnt = 0;
        return s;
    endfunction

    function automatic bit mtx(ms_t s);
        return (s.st != 0) ? prbs[(s.n - 1) % 127] : 1'b0;
    endfunction

    task automatic cmp_all();
        check("tx_a", tx_a, mtx(ma));
        check("locked_a", lk_a, ma.st == 3);
        check("err_a", err_a, ma.err);
        check("cnt_a", cnt_a, ma.cnt);
        check("tx_b", tx_b, mtx(mb));
        check("locked_b", lk_b, mb.st == 3);
        check("err_b", err_b, mb.err);
        check("cnt_b", cnt_b, mb.cnt);
    endtask

    task automatic cyc();
        ci_a = ta[d_a] ^ inv_a;
        ci_b = (mode_b == 1) ? 1'b0 : hb[L] ^ (mode_b == 2);
        @(posedge clk);
        if (!rst_n) begin
            ma = '{default: 0};
            mb = '{default: 0};
        end else begin
            ma = mstep(ma, en, clr_a, ci_a, 4, 65535);
            mb = mstep(mb, en, clr_b, ci_b, 255, 7);
        end
        #1;
        cmp_all();
        for (int i = 127; i > 0; i--) begin
            ta[i] = ta[i-1];
            hb[i] = hb[i-1];
        end
        ta[0] = tx_a;
        hb[0] = tx_b;
    endtask

    task automatic lock_seq(input string tag);
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (i == 12) check({tag, "_unlocked13"}, lk_a, 1'b0);
        end
        check({tag, "_locked14"}, lk_a, 1'b1);
        check({tag, "_locked14_b"}, lk_b, 1'b1);
    endtask

    initial begin
        logic [6:0] l;
        logic [7:0] first;
        bit ever;
        l = 7'h7F;
        for (int i = 0; i < 127; i++) begin
            prbs[i] = l[6];
            l = {l[5:0], l[6] ^ l[5]};
        end
        ma = '{default: 0};
        mb = '{default: 0};
        #2;
        cmp_all();
        cyc();
        cyc();
        rst_n = 1'b1;
        en = 1'b1;
        first = 8'b1111_1110;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (i < 8) check("tx_start", tx_a, first[7-i]);
            if (i == 12) check("unlocked13", lk_a, 1'b0);
        end
        check("locked14", lk_a, 1'b1);

        repeat (1000) begin
            clr_a = ($urandom_range(0, 31) == 0);
            cyc();
        end
        clr_a = 1'b0;
        check("clean_cnt", cnt_a, 0);
        check("clean_lock", lk_a, 1'b1);

        inv_a = 1'b1;
        cyc();
        inv_a = 1'b0;
        check("single_err", err_a, 1'b1);
        check("single_lock", lk_a, 1'b1);
        cyc();
        check("single_err_end", err_a, 1'b0);
        check("single_cnt", cnt_a, 1);

        inv_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("burst_lock", lk_a, i < 3);
        end
        inv_a = 1'b0;
        check("burst_cnt", cnt_a, 5);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("relock", lk_a, i == 7);
        end

        repeat (400) begin
            inv_a = ($urandom_range(0, 11) == 0);
            clr_a = ($urandom_range(0, 39) == 0);
            cyc();
        end
        inv_a = 1'b0;
        clr_a = 1'b0;
        repeat (20) cyc();

        mode_b = 1;
        repeat (40) cyc();
        check("sat_cnt", cnt_b, 7);
        check("sat_lock", lk_b, 1'b1);
        mode_b = 2;
        clr_b = 1'b1;
        cyc();
        check("clr_miss_cnt", cnt_b, 0);
        check("clr_miss_err", err_b, 1'b1);
        clr_b = 1'b0;
        mode_b = 0;
        repeat (5) cyc();

        check("pre_reset_lock", lk_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_tx", tx_a, 1'b0);
        check("rst_locked", lk_a, 1'b0);
        check("rst_err", err_a, 1'b0);
        check("rst_cnt", cnt_a, 0);
        check("rst_cnt_b", cnt_b, 0);
        ma = '{default: 0};
        mb = '{default: 0};
        cyc();
        rst_n = 1'b1;
        lock_seq("post_reset");

        inv_a = 1'b1;
        cyc();
        cyc();
        inv_a = 1'b0;
        cyc();
        check("two_err_cnt", cnt_a, 2);
        en = 1'b0;
        cyc();
        check("idle_tx", tx_a, 1'b0);
        check("idle_lock", lk_a, 1'b0);
        check("idle_cnt", cnt_a, 2);
        repeat (3) cyc();

        clr_a = 1'b1;
        cyc();
        clr_a = 1'b0;
        d_a = L + 1;
        en = 1'b1;
        ever = 1'b0;
        repeat (2000) begin
            cyc();
            if (lk_a) ever = 1'b1;
        end
        check("offset_never_locked", ever, 1'b0);
        check("offset_cnt", cnt_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
